mr1_mem_responder: RTL

//  Memory-side responder for the MR1 instruction and data request/response buses.

---
 rtl/mr1_mem_responder_if.sv | 34 +++
 rtl/mr1_mem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mr1_mem_responder_if.sv
// Request/response bundle between an MR1 core (master) and the memory
// responder (slave): one fetch port, one load/store port and the sticky error flag.
interface mr1_mem_responder_if;
  logic        instr_req_valid;
  logic        instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;

  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_wr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_addr;
  logic [31:0] data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;

  logic        misalign_err;

  modport master (
    output instr_req_valid, instr_req_addr,
    output data_req_valid, data_req_wr, data_req_size, data_req_addr, data_req_data,
    input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
    input  data_req_ready, data_rsp_valid, data_rsp_data, misalign_err
  );

  modport slave (
    input  instr_req_valid, instr_req_addr,
    input  data_req_valid, data_req_wr, data_req_size, data_req_addr, data_req_data,
    output instr_req_ready, instr_rsp_valid, instr_rsp_data,
    output data_req_ready, data_rsp_valid, data_rsp_data, misalign_err
  );
endinterface

// File: rtl/mr1_mem_responder.sv
// Fixed-latency memory responder for the MR1 fetch and load/store buses.
// One shared word array: fetch port read-only, data port read/write with byte enables.
module mr1_mem_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  mr1_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [31:0]                  mem_q [MEM_WORDS];
  logic [15:0]                  lfsr_q, lfsr_d;
  logic                         instr_ready_q, instr_ready_d;
  logic                         data_ready_q, data_ready_d;
  logic                         misalign_q, misalign_d;
  logic [RD_LATENCY-1:0]        ivld_q, ivld_d;
  logic [RD_LATENCY-1:0]        dvld_q, dvld_d;
  logic [RD_LATENCY-1:0][31:0]  idat_q, idat_d;
  logic [RD_LATENCY-1:0][31:0]  ddat_q, ddat_d;

  logic                         instr_acc_s;
  logic                         data_acc_s;
  logic [IDX_W-1:0]             iidx_s;
  logic [IDX_W-1:0]             didx_s;
  logic                         aligned_s;
  logic [3:0]                   lane_we_s;
  logic [31:0]                  lane_wdata_s;
  logic [3:0]                   store_we_s;
  logic                         unused_addr_bits_s;

  // Accept decode and store lane steering
  always_comb begin
    instr_acc_s  = bus.instr_req_valid & instr_ready_q;
    data_acc_s   = bus.data_req_valid & data_ready_q;
    iidx_s       = bus.instr_req_addr[IDX_W+1:2];
    didx_s       = bus.data_req_addr[IDX_W+1:2];
    aligned_s    = 1'b0;
    lane_we_s    = 4'b0000;
    lane_wdata_s = bus.data_req_data;
    case (bus.data_req_size)
      2'd0: begin
        aligned_s    = 1'b1;
        lane_we_s    = 4'b0001 << bus.data_req_addr[1:0];
        lane_wdata_s = {4{bus.data_req_data[7:0]}};
      end
      2'd1: begin
        aligned_s    = ~bus.data_req_addr[0];
        lane_we_s    = bus.data_req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata_s = {2{bus.data_req_data[15:0]}};
      end
      2'd2: begin
        aligned_s    = (bus.data_req_addr[1:0] == 2'b00);
        lane_we_s    = 4'b1111;
        lane_wdata_s = bus.data_req_data;
      end
      default: begin
        aligned_s    = 1'b0;
        lane_we_s    = 4'b0000;
        lane_wdata_s = bus.data_req_data;
      end
    endcase
    // Nothing is written on a reset edge so memory survives reset untouched
    if (data_acc_s && bus.data_req_wr && aligned_s && reset_n) begin
      store_we_s = lane_we_s;
    end else begin
      store_we_s = 4'b0000;
    end
    unused_addr_bits_s = ^{bus.instr_req_addr[31:IDX_W+2], bus.instr_req_addr[1:0],
                           bus.data_req_addr[31:IDX_W+2]};
  end

  // Next-state for LFSR, ready, sticky error and both response pipelines
  always_comb begin
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    instr_ready_d = STALL_EN ? lfsr_d[0] : 1'b1;
    data_ready_d  = STALL_EN ? lfsr_d[1] : 1'b1;
    if (data_acc_s && !aligned_s) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = misalign_q;
    end
    ivld_d    = ivld_q;
    idat_d    = idat_q;
    dvld_d    = dvld_q;
    ddat_d    = ddat_q;
    ivld_d[0] = instr_acc_s;
    idat_d[0] = instr_acc_s ? mem_q[iidx_s] : 32'd0;
    // Misaligned loads still answer, but with zero data
    dvld_d[0] = data_acc_s & ~bus.data_req_wr;
    ddat_d[0] = (data_acc_s && !bus.data_req_wr && aligned_s) ? mem_q[didx_s] : 32'd0;
    for (int k = 1; k < RD_LATENCY; k++) begin
      ivld_d[k] = ivld_q[k-1];
      idat_d[k] = idat_q[k-1];
      dvld_d[k] = dvld_q[k-1];
      ddat_d[k] = ddat_q[k-1];
    end
  end

  // Control and pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q        <= LFSR_SEED;
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
      misalign_q    <= 1'b0;
      ivld_q        <= '0;
      idat_q        <= '0;
      dvld_q        <= '0;
      ddat_q        <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      instr_ready_q <= instr_ready_d;
      data_ready_q  <= data_ready_d;
      misalign_q    <= misalign_d;
      ivld_q        <= ivld_d;
      idat_q        <= idat_d;
      dvld_q        <= dvld_d;
      ddat_q        <= ddat_d;
    end
  end

  // Byte-enabled array write; reads above see the pre-edge contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (store_we_s[b]) begin
        mem_q[didx_s][8*b +: 8] <= lane_wdata_s[8*b +: 8];
      end
    end
  end

  assign bus.instr_req_ready = instr_ready_q;
  assign bus.data_req_ready  = data_ready_q;
  assign bus.instr_rsp_valid = ivld_q[RD_LATENCY-1];
  assign bus.instr_rsp_data  = idat_q[RD_LATENCY-1];
  assign bus.data_rsp_valid  = dvld_q[RD_LATENCY-1];
  assign bus.data_rsp_data   = ddat_q[RD_LATENCY-1];
  assign bus.misalign_err    = misalign_q;

endmodule
